// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the Ascon permutation: steps the 320-bit state datapath
// through p^a or p^b and produces the round index and round constant.
module ascon_round_ctrl #(
    parameter int NR_A = 12,
    parameter int NR_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_a_i,
    output logic       load_o,
    output logic       state_en_o,
    output logic [3:0] round_o,
    output logic [7:0] round_cst_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Rounds always finish at index 11; shorter permutations start later.
    localparam logic [3:0] FIRST_A    = 4'(12 - NR_A);
    localparam logic [3:0] FIRST_B    = 4'(12 - NR_B);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    state_t     state_q;
    state_t     state_d;
    logic       mode_q;
    logic [3:0] cnt_q;
    logic [3:0] first_idx;
    logic       cst_on;

    assign first_idx = mode_q ? FIRST_A : FIRST_B;

    // Request handshake: start_i is a level request taken only in IDLE; busy_o
    // covers LOAD..DONE, and any request seen while busy is dropped, not queued.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q <= mode_a_i;
                    end
                end
                LOAD: begin
                    cnt_q <= first_idx;
                end
                ROUND: begin
                    if (cnt_q != LAST_ROUND) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    cnt_q <= 4'd0;
                end
                default: begin
                    cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // Outputs decode state and counter only; start_i affects next state alone.
    always_comb begin
        state_d    = state_q;
        load_o     = 1'b0;
        state_en_o = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        cst_on     = 1'b0;
        round_o    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_o     = 1'b1;
                state_en_o = 1'b1;
                busy_o     = 1'b1;
                cst_on     = 1'b1;
                round_o    = first_idx;
                state_d    = ROUND;
            end
            ROUND: begin
                state_en_o = 1'b1;
                busy_o     = 1'b1;
                cst_on     = 1'b1;
                if (cnt_q == LAST_ROUND) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign round_cst_o = cst_on ? {4'd15 - round_o, round_o} : 8'h00;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Bench for ascon_round_ctrl: a per-cycle expected-trace model built from the
// permutation schedule, checked against directed and random request patterns.
module tb_ascon_round_ctrl;

    localparam int NR_A = 12;
    localparam int NR_B = 6;

    logic       clock_i;
    logic       reset_i;
    logic       start_i;
    logic       mode_a_i;
    logic       load_o;
    logic       state_en_o;
    logic [3:0] round_o;
    logic [7:0] round_cst_o;
    logic       busy_o;
    logic       done_o;

    ascon_round_ctrl #(.NR_A(NR_A), .NR_B(NR_B)) dut (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .mode_a_i   (mode_a_i),
        .load_o     (load_o),
        .state_en_o (state_en_o),
        .round_o    (round_o),
        .round_cst_o(round_cst_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // ---- clock / reset ----
    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // ---- scoreboard ----
    // Record layout: {load, en, round[3:0], cst[7:0], busy, done}
    logic [15:0] exp_q[$];
    int n_tests     = 0;
    int n_fail      = 0;
    int n_done_seen = 0;
    int n_done_exp  = 0;
    int n_en_seen   = 0;

    function automatic logic [15:0] rec(input logic ld, input logic en, input int r,
                                        input logic cst_on, input logic busy, input logic done);
        logic [7:0] cst;
        cst = cst_on ? {4'(15 - r), 4'(r)} : 8'h00;
        return {ld, en, 4'(r), cst, busy, done};
    endfunction

    // One whole permutation as seen at the outputs, cycle by cycle.
    task automatic push_run(input logic mode_a);
        int nr;
        int f;
        nr = mode_a ? NR_A : NR_B;
        f  = 12 - nr;
        exp_q.push_back(rec(1'b1, 1'b1, f, 1'b1, 1'b1, 1'b0));
        for (int r = f; r <= 11; r++) begin
            exp_q.push_back(rec(1'b0, 1'b1, r, 1'b1, 1'b1, 1'b0));
        end
        exp_q.push_back(rec(1'b0, 1'b0, 11, 1'b0, 1'b1, 1'b1));
    endtask

    task automatic model_edge(input logic rst, input logic st, input logic md);
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (st) push_run(md);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    function automatic logic [15:0] expected_now();
        return (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
    endfunction

    task automatic check_int(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [15:0] obs;
        logic [15:0] exp_v;
        obs   = {load_o, state_en_o, round_o, round_cst_o, busy_o, done_o};
        exp_v = expected_now();
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
        if (done_o === 1'b1) n_done_seen++;
        if (state_en_o === 1'b1) n_en_seen++;
        if (exp_v[0]) n_done_exp++;
    endtask

    // ---- driver ----
    task automatic step(input logic rst, input logic st, input logic md, input string tag);
        @(negedge clock_i);
        reset_i  = rst;
        start_i  = st;
        mode_a_i = md;
        @(posedge clock_i);
        model_edge(rst, st, md);
        #1;
        check_outputs(tag);
    endtask

    // ---- directed + random sequence ----
    initial begin
        int lat;
        int en_base;
        logic hit;
        reset_i  = 1'b1;
        start_i  = 1'b0;
        mode_a_i = 1'b0;

        // Reset, with a start request that reset must dominate
        step(1'b1, 1'b0, 1'b0, "reset");
        step(1'b1, 1'b1, 1'b1, "reset_vs_start");
        step(1'b0, 1'b0, 1'b0, "idle_after_reset");

        // p^a: full 12 rounds, latency to done
        step(1'b0, 1'b1, 1'b1, "pa_load");
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0, "pa_run");
            if (done_o === 1'b1 && lat < 0) lat = i;
        end
        check_int("pa_done_latency", lat, NR_A + 1);

        // p^b: 6 rounds from index 6, state_en width
        en_base = n_en_seen;
        step(1'b0, 1'b1, 1'b0, "pb_load");
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0, 1'b0, "pb_run");
            if (done_o === 1'b1 && lat < 0) lat = i;
        end
        check_int("pb_done_latency", lat, NR_B + 1);
        check_int("pb_state_en_cycles", n_en_seen - en_base, NR_B + 1);

        // Requests while busy and in DONE are ignored
        step(1'b0, 1'b1, 1'b1, "busy_req_load");
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            step(1'b0, 1'b1, 1'($urandom_range(0, 1)), "busy_req");
        end
        step(1'b0, 1'b0, 1'b0, "busy_req_idle");
        check_int("busy_req_done_count", n_done_seen, n_done_exp);

        // Continuous start, p^b: back-to-back 9-cycle periods
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 1'b0, "held_start");
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, "held_drain");
        check_int("held_done_count", n_done_seen, n_done_exp);

        // Abort at round 8 of p^a
        step(1'b0, 1'b1, 1'b1, "abort_load");
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (exp_q.size() != 0 && exp_q[0][14] && !exp_q[0][15] && exp_q[0][13:10] == 4'd8)
                hit = 1'b1;
            else
                step(1'b0, 1'b0, 1'b0, "abort_wait");
        end
        check_int("abort_reached_r8", int'(hit), 1);
        step(1'b1, 1'b0, 1'b0, "abort_reset");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, "abort_quiet");

        // p^b with mode_a_i toggling after acceptance
        step(1'b0, 1'b1, 1'b0, "toggle_load");
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 1'(i % 2 == 0), "toggle_run");
        end

        // Random requests, modes and occasional resets
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), "random");
        end
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, "final_drain");
        check_int("final_done_count", n_done_seen, n_done_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
